// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain clock/data pull-low enables.
// Optional macro PS2_TX_RETRY_EN: a first NACK re-sends the same byte once before reporting an error.
//
// state   | meaning
// IDLE    | lines released, waiting for tx_valid
// INHIBIT | clock held low for INHIBIT_CYCLES
// REQ     | start bit driven, clock released, waiting for first device fall
// SEND    | 8 data bits, parity, stop shifted out on falls
// ACK     | sample device acknowledge on the next fall
// WAIT_HI | wait for both lines idle before reporting done
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int CNT_W          = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] err_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_HI} state_t;

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             par_q, par_d;
    logic             clk_meta_q, clk_sync_q, clk_prev_q;
    logic             data_meta_q, data_sync_q;
    logic             clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
    logic             done_q, done_d, error_q, error_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             retry_go;
`ifdef PS2_TX_RETRY_EN
    logic             retry_q, retry_d;
`endif

    logic fall, cnt_run, hi_ok, tmo, inh_done, accept;

    assign fall     = clk_prev_q & ~clk_sync_q;
    assign cnt_run  = (state_q == S_REQ) || (state_q == S_SEND) ||
                      (state_q == S_ACK) || (state_q == S_WAIT_HI);
    assign hi_ok    = (state_q == S_WAIT_HI) && clk_sync_q && data_sync_q;
    // Fires on the edge where the counter would reach TIMEOUT_CYCLES; a fall always wins.
    assign tmo      = cnt_run && !fall && !hi_ok && (cnt_q == TIMEOUT_LAST);
    assign inh_done = (state_q == S_INHIBIT) && (cnt_q == INHIBIT_LAST);
    assign tx_ready = (state_q == S_IDLE) && !done_q && !error_q;
    assign busy     = (state_q != S_IDLE);
    assign accept   = tx_valid && tx_ready;

`ifdef PS2_TX_RETRY_EN
    assign retry_go = !retry_q;
`else
    assign retry_go = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            par_q       <= 1'b0;
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= 2'b00;
`ifdef PS2_TX_RETRY_EN
            retry_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            clk_meta_q  <= ps2_clk_in;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_in;
            data_sync_q <= data_meta_q;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
`ifdef PS2_TX_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
`ifdef PS2_TX_RETRY_EN
        retry_d  = retry_q;
`endif
        if (cnt_run || state_q == S_INHIBIT) cnt_d = cnt_q + CNT_W'(1);
        case (state_q)
            S_IDLE: if (accept) begin
                shreg_d = tx_data;
                par_d   = ~^tx_data;
                cnt_d   = '0;
                state_d = S_INHIBIT;
            end
            S_INHIBIT: if (inh_done) begin
                cnt_d   = '0;
                state_d = S_REQ;
            end
            S_REQ: if (fall) begin
                cnt_d    = '0;
                bitcnt_d = 4'd0;
                state_d  = S_SEND;
            end
            S_SEND: if (fall) begin
                cnt_d    = '0;
                bitcnt_d = bitcnt_q + 4'd1;
                if (bitcnt_q == 4'd9) state_d = S_ACK;
            end
            S_ACK: if (fall) begin
                cnt_d = '0;
                if (!data_sync_q) state_d = S_WAIT_HI;
                else if (retry_go) begin
                    state_d = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_d = 1'b1;
`endif
                end else state_d = S_IDLE;
            end
            S_WAIT_HI: if (hi_ok) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (tmo) state_d = S_IDLE;
`ifdef PS2_TX_RETRY_EN
        if (state_d == S_IDLE) retry_d = 1'b0;
`endif
    end

    always_comb begin
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        err_code_d = err_code_q;
        case (state_q)
            S_IDLE: begin
                clk_oe_d  = accept;
                data_oe_d = 1'b0;
            end
            S_INHIBIT: if (inh_done) begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b1;
            end
            S_SEND: if (fall) begin
                if (bitcnt_q < 4'd8)       data_oe_d = ~shreg_q[bitcnt_q[2:0]];
                else if (bitcnt_q == 4'd8) data_oe_d = ~par_q;
                else                       data_oe_d = 1'b0;
            end
            S_ACK: if (fall && data_sync_q) begin
                data_oe_d = 1'b0;
                if (retry_go) clk_oe_d = 1'b1;
                else begin
                    clk_oe_d   = 1'b0;
                    error_d    = 1'b1;
                    err_code_d = 2'b01;
                end
            end
            S_WAIT_HI: if (hi_ok) done_d = 1'b1;
            default: ;
        endcase
        if (tmo) begin
            clk_oe_d   = 1'b0;
            data_oe_d  = 1'b0;
            error_d    = 1'b1;
            err_code_d = 2'b10;
        end
    end

    assign tx_done     = done_q;
    assign tx_error    = error_q;
    assign err_code    = err_code_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboarded bench for ps2_host_tx with a PS/2 device model clocking at 40 clk per bit.
module tb_ps2_host_tx;
    localparam int INH = 20;
    localparam int TMO = 200;

    typedef struct {
        int nclk;
        bit nack;
        bit cmp;
    } dev_cfg_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_error;
    logic [1:0] err_code;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .CNT_W(20)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .tx_done(tx_done), .tx_error(tx_error),
        .err_code(err_code), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_frame_q[$];
    int          exp_resp_q[$];
    dev_cfg_t    dev_q[$];
    int dev_last_fall = 0;
    int dev_falls = 0;
    bit dev_busy = 1'b0;
    int pulse_cnt = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Device: 12 clocks per frame, samples on rising edges, acks during clock 11/12.
    initial begin : device
        dev_cfg_t    c;
        logic [10:0] fr;
        forever begin
            @(negedge clk);
            if (!rst && ps2_clk_in && !ps2_data_in && dev_q.size() > 0) begin
                c = dev_q.pop_front();
                dev_busy = 1'b1;
                dev_falls = 0;
                fr = '0;
                repeat (10) @(negedge clk);
                for (int k = 1; k <= c.nclk; k++) begin
                    dev_clk_low = 1'b1;
                    dev_falls = k;
                    dev_last_fall = cyc;
                    repeat (20) @(negedge clk);
                    dev_clk_low = 1'b0;
                    if (k <= 11) fr[k-1] = ps2_data_in;
                    if (k == 12) dev_data_low = 1'b0;
                    repeat (10) @(negedge clk);
                    if (k == 11 && !c.nack) dev_data_low = 1'b1;
                    repeat (10) @(negedge clk);
                end
                dev_data_low = 1'b0;
                if (c.cmp) begin
                    if (exp_frame_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL frame_unexpected actual=%0h expected=none", fr);
                    end else chk("frame_bits", int'(fr), int'(exp_frame_q.pop_front()));
                end
                dev_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : monitor
        int act;
        int inh_run;
        bit ready_next;
        if (ready_next) begin
            chk("ready_after_pulse", int'(tx_ready), 1);
            chk("busy_after_pulse", int'(busy), 0);
        end
        ready_next = 1'b0;
        if (!rst && (tx_done || tx_error)) begin
            act = tx_done ? (tx_error ? 9 : 0) : int'(err_code);
            if (exp_resp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_pulse actual=%0d expected=none", act);
            end else begin
                int e;
                e = exp_resp_q.pop_front();
                chk("response", act, e);
                if (e == 2) chk("timeout_cycle", cyc, dev_last_fall + 3 + TMO);
            end
            chk("oe_at_pulse", int'({ps2_clk_oe, ps2_data_oe}), 0);
            pulse_cnt++;
            if (tx_done) done_cnt++;
            ready_next = 1'b1;
        end
        if (ps2_clk_oe) inh_run++;
        else begin
            if (inh_run > 0) begin
                chk("inhibit_len", inh_run, INH);
                chk("start_bit_oe", int'(ps2_data_oe), 1);
            end
            inh_run = 0;
        end
    end

    task automatic accept(input logic [7:0] b, input bit hold);
        int n;
        n = 0;
        tx_data = b;
        tx_valid = 1'b1;
        while (!tx_ready && n < 4000) begin @(negedge clk); n++; end
        chk("accept_ready", int'(tx_ready), 1);
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(exp_resp_q.size() == 0 && !dev_busy && tx_ready) && n < 4000) begin
            @(negedge clk); n++;
        end
        chk("idle_reached", int'(n < 4000), 1);
        repeat (5) @(negedge clk);
    endtask

    task automatic expect_frame(input logic [7:0] b, input logic par, input bit nack, input int resp);
        dev_q.push_back('{nclk: 12, nack: nack, cmp: 1'b1});
        exp_frame_q.push_back({1'b1, par, b, 1'b0});
        if (resp >= 0) exp_resp_q.push_back(resp);
    endtask

    initial begin
        int base, n, pc;
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", int'(tx_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tx_done", int'(tx_done), 0);
        chk("rst_tx_error", int'(tx_error), 0);
        chk("rst_err_code", int'(err_code), 0);
        chk("rst_clk_oe", int'(ps2_clk_oe), 0);
        chk("rst_data_oe", int'(ps2_data_oe), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 0xED: bits LSB first 1,0,1,1,0,1,1,1, six ones -> parity 1
        expect_frame(8'hED, 1'b1, 1'b0, 0);
        accept(8'hED, 1'b0);
        wait_idle();
        chk("ed_busy", int'(busy), 0);

        // 0x01 (parity 0) then 0xFF (parity 1) with tx_valid held
        expect_frame(8'h01, 1'b0, 1'b0, 0);
        expect_frame(8'hFF, 1'b1, 1'b0, 0);
        accept(8'h01, 1'b1);
        base = done_cnt;
        accept(8'hFF, 1'b0);
        chk("b2b_after_done", done_cnt, base + 1);
        wait_idle();

        // 0xF4 NACKed (five ones -> parity 0)
`ifdef PS2_TX_RETRY_EN
        expect_frame(8'hF4, 1'b0, 1'b1, -1);
        expect_frame(8'hF4, 1'b0, 1'b1, 1);
        accept(8'hF4, 1'b0);
        wait_idle();
        chk("nack_err_code", int'(err_code), 1);
        expect_frame(8'hF4, 1'b0, 1'b1, -1);
        expect_frame(8'hF4, 1'b0, 1'b0, 0);
        accept(8'hF4, 1'b0);
        wait_idle();
`else
        expect_frame(8'hF4, 1'b0, 1'b1, 1);
        accept(8'hF4, 1'b0);
        wait_idle();
        chk("nack_err_code", int'(err_code), 1);
`endif

        // Device stops after 5 clocks (start + 4 data bits)
        dev_q.push_back('{nclk: 5, nack: 1'b0, cmp: 1'b0});
        exp_resp_q.push_back(2);
        accept(8'h55, 1'b0);
        wait_idle();
        chk("tmo_err_code", int'(err_code), 2);

        // Reset while bit 5 is on the line (driven after fall 7)
        dev_q.push_back('{nclk: 8, nack: 1'b0, cmp: 1'b0});
        accept(8'hA5, 1'b0);
        n = 0;
        while (!(dev_busy && dev_falls == 7) && n < 3000) begin @(negedge clk); n++; end
        chk("reach_bit5", int'(n < 3000), 1);
        repeat (6) @(negedge clk);
        pc = pulse_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
        chk("mid_rst_ready", int'(tx_ready), 1);
        chk("mid_rst_busy", int'(busy), 0);
        n = 0;
        while (dev_busy && n < 3000) begin @(negedge clk); n++; end
        repeat (20) @(negedge clk);
        chk("mid_rst_no_pulse", pulse_cnt, pc);

        expect_frame(8'hED, 1'b1, 1'b0, 0);
        accept(8'hED, 1'b0);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It is the send side of the existing ps2_keyboard receiver.
- Sends command bytes to the keyboard, for example 0xED (set LEDs), 0xFF (reset) and 0xF4 (enable).
- Drives the open-drain ps2_clk/ps2_data lines through active-high "pull low" enables. It reports completion or error to the keyboard_processor-level control logic.
- Shares the physical PS/2 pins with ps2_keyboard. While busy=1, the receiver's input frames must be ignored.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles that ps2_clk is held low before the request (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum clk cycles allowed between REQ entry or the last ps2_clk falling edge and the next falling edge (15 ms at 50 MHz).
- CNT_W, 20: width of the shared cycle counter. Must satisfy 2^CNT_W > max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  8  command byte to send.
- tx_valid  in  1  request. The byte is accepted when tx_valid & tx_ready.
- tx_ready  out  1  high only in IDLE.
- busy  out  1  high in every state except IDLE.
- tx_done  out  1  one-cycle pulse: frame sent and ACK received.
- tx_error  out  1  one-cycle pulse: NACK or timeout.
- err_code  out  2  valid with tx_error: 2'b01 = NACK, 2'b10 = timeout. Holds until the next tx_error.
- ps2_clk_in  in  1  raw PS/2 clock line (asynchronous).
- ps2_data_in  in  1  raw PS/2 data line (asynchronous).
- ps2_clk_oe  out  1  1 = pull the clock line low, 0 = release it.
- ps2_data_oe  out  1  1 = pull the data line low, 0 = release it.

Behaviour:
- Clocking and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: tx_ready=1, busy=0, tx_done=0, tx_error=0, err_code=0, ps2_clk_oe=0, ps2_data_oe=0, state=IDLE.
- Reset mid-frame: both lines are released on the reset edge and no done/error pulse is produced.
- Input synchronisation: ps2_clk_in passes through 2 flip-flops, then a previous-value register. A falling edge (fall) is prev=1 and cur=0.
  - Synchronised data is sampled from a 2-flip-flop copy of ps2_data_in.
  - Edge detection latency is 3 clk cycles from the line transition.
- Byte capture: on accept, tx_data is latched into shreg[7:0] and odd parity is computed: par = ~^tx_data.
- IDLE: both oe=0. When tx_valid=1, latch the byte, clear the counter and go to INHIBIT. tx_valid held high is ignored in all other states.
- INHIBIT: clk_oe=1, data_oe=0. After INHIBIT_CYCLES cycles, set data_oe=1 (start bit) and go to REQ on the same edge.
- REQ: clk_oe=0, data_oe=1. Reset the counter on entry. On fall: bitcnt=0 and go to SEND.
- SEND: on each fall, the host drives the bit for index bitcnt, then increments bitcnt. data_oe = ~bit.
  - bitcnt 0..7: shreg[bitcnt], LSB first.
  - bitcnt 8: par.
  - bitcnt 9: data_oe=0 (stop bit, line released), then go to ACK.
- ACK: on the next fall, sample the synchronised data.
  - 0: go to WAIT_HI.
  - 1: tx_error=1, err_code=01, go to IDLE.
- WAIT_HI: wait for the synchronised clock = 1 and synchronised data = 1 (line idle). Then tx_done=1 and go to IDLE.
- Timeout: in REQ, SEND, ACK and WAIT_HI the counter increments every cycle and clears on each fall.
  - When the counter reaches TIMEOUT_CYCLES: both oe=0, tx_error=1, err_code=10, go to IDLE.
  - A timeout and a fall in the same cycle: the fall wins.
- tx_done and tx_error are never high together. tx_ready rises on the cycle after either pulse.
- No ps2_clk activity is acted on in IDLE or INHIBIT.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined: a NACK does not pulse tx_error at the first attempt. Instead the block re-enters INHIBIT with the same byte, and busy stays 1.
  - A 1-bit retry flag allows one retry.
  - If the second attempt is also NACKed, tx_error=1 with err_code=01.
  - A timeout is never retried.
  - The retry flag clears on IDLE entry.
- Undefined: a NACK immediately produces the error as described in Behaviour, and no retry logic is present.

Test Plan:
- Bench setup: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200. The device model generates ps2_clk with a 40-cycle period, samples data on rising edges, and pulls data low during the 11th clock.
- Send 0xED -> clk_oe high for exactly 20 cycles, then data_oe=1. The device samples start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. ACK gives tx_done pulse, busy=0, tx_ready=1.
- Send 0x01, then 0xFF back-to-back (tx_valid held high) -> the second byte is accepted only after tx_done. Parities are 0 and 1 respectively, and both frames complete.
- Device NACK (data=1 at the 11th clock) for 0xF4 -> tx_error with err_code=01. With PS2_TX_RETRY_EN: two full frames; tx_error only after the second NACK, and tx_done if the retry is ACKed.
- Device stops clocking after 4 bits -> tx_error and err_code=10 exactly 200 cycles after the last detected fall. Both oe=0 on the same edge.
- rst asserted during SEND bit 5 -> next cycle both oe=0, state IDLE, tx_ready=1, no tx_done or tx_error pulse. A fresh send of 0xED then succeeds.
